// File: rtl/alu_spi_master_if.sv
// SPI bus between the ALU request master and the SPI ALU slave.
interface alu_spi_master_if;
    logic nss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output nss, output sclk, output mosi, input miso);
    modport slave  (input nss, input sclk, input mosi, output miso);
endinterface

// File: rtl/alu_spi_master.sv
// Serialises one ALU request (opcode, A, B) over SPI and reads back the 32-bit result.
module alu_spi_master #(
    parameter int unsigned SCLK_LOW_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_opcode,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    output logic              rsp_valid,
    output logic [31:0]       rsp_result,
    output logic              rsp_zero,
    alu_spi_master_if.master  spi_if
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LOW,
        WR_HIGH,
        WAIT_EXEC,
        READ
    } state_t;

    localparam logic [7:0] LOW_LAST = 8'(SCLK_LOW_CYCLES);
    localparam logic [6:0] WR_LAST  = 7'd67;
    localparam logic [6:0] RD_LAST  = 7'd31;

    state_t      state;
    logic [66:0] frame;      // bits still to send after the one on mosi
    logic [6:0]  bit_idx;
    logic [7:0]  low_cnt;
    logic [30:0] shift;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            frame       <= '0;
            bit_idx     <= '0;
            low_cnt     <= '0;
            shift       <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            spi_if.nss  <= 1'b1;
            spi_if.sclk <= 1'b0;
            spi_if.mosi <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state       <= WR_LOW;
                        frame       <= {req_opcode[2:0], req_a, req_b};
                        spi_if.mosi <= req_opcode[3];
                        bit_idx     <= '0;
                        low_cnt     <= 8'd1;
                        req_ready   <= 1'b0;
                        spi_if.nss  <= 1'b0;
                        spi_if.sclk <= 1'b0;
                    end
                end
                WR_LOW: begin
                    if (low_cnt == LOW_LAST) begin
                        state       <= WR_HIGH;
                        spi_if.sclk <= 1'b1;
                    end else begin
                        low_cnt <= low_cnt + 8'd1;
                    end
                end
                WR_HIGH: begin
                    spi_if.sclk <= 1'b0;
                    if (bit_idx == WR_LAST) begin
                        state       <= WAIT_EXEC;
                        spi_if.mosi <= 1'b0;
                    end else begin
                        state       <= WR_LOW;
                        bit_idx     <= bit_idx + 7'd1;
                        low_cnt     <= 8'd1;
                        spi_if.mosi <= frame[66];
                        frame       <= {frame[65:0], 1'b0};
                    end
                end
                WAIT_EXEC: begin
                    state   <= READ;
                    bit_idx <= '0;
                end
                READ: begin
                    shift <= {shift[29:0], spi_if.miso};
                    if (bit_idx == RD_LAST) begin
                        state      <= IDLE;
                        rsp_result <= {shift, spi_if.miso};
                        rsp_zero   <= ({shift, spi_if.miso} == 32'd0);
                        rsp_valid  <= 1'b1;
                        req_ready  <= 1'b1;
                        spi_if.nss <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_spi_master.sv
// Randomised and directed checks of alu_spi_master against a request-level ALU model and SPI slave model.
module tb_alu_spi_master;

    localparam int unsigned L0 = 1;
    localparam int unsigned L1 = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rv [2];
    logic [3:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rdy [2];
    logic        vld [2];
    logic        zr [2];
    logic [31:0] result [2];

    int n_vec = 0;
    int n_bad = 0;

    bit nss_q[$];
    bit sclk_q[$];
    bit mosi_q[$];

    always #5 clock = ~clock;

    alu_spi_master_if spi0 ();
    alu_spi_master_if spi1 ();

    alu_spi_master #(.SCLK_LOW_CYCLES(L0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(vld[0]), .rsp_result(result[0]), .rsp_zero(zr[0]), .spi_if(spi0)
    );

    alu_spi_master #(.SCLK_LOW_CYCLES(L1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(vld[1]), .rsp_result(result[1]), .rsp_zero(zr[1]), .spi_if(spi1)
    );

    logic [1:0] s_nss, s_sclk, s_mosi;
    logic [1:0] s_miso = '0;
    assign s_nss  = {spi1.nss, spi0.nss};
    assign s_sclk = {spi1.sclk, spi0.sclk};
    assign s_mosi = {spi1.mosi, spi0.mosi};
    assign spi0.miso = s_miso[0];
    assign spi1.miso = s_miso[1];

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return sa >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Slave model: samples mosi on sclk-high cycles, one execute cycle, then presents result MSB first.
    logic [67:0] sh [2];
    int          cnt [2];
    int          phase [2];
    int          ridx [2];
    logic [31:0] sres [2];

    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (s_nss[u] !== 1'b0) begin
                cnt[u]    <= 0;
                phase[u]  <= 0;
                s_miso[u] <= 1'b0;
            end else begin
                case (phase[u])
                    0: if (s_sclk[u] === 1'b1) begin
                        sh[u]  <= {sh[u][66:0], s_mosi[u]};
                        cnt[u] <= cnt[u] + 1;
                        if (cnt[u] == 67) begin
                            sres[u]  <= alu_ref(sh[u][66:63], sh[u][62:31], {sh[u][30:0], s_mosi[u]});
                            phase[u] <= 1;
                        end
                    end
                    1: begin
                        phase[u]  <= 2;
                        s_miso[u] <= sres[u][31];
                        ridx[u]   <= 1;
                    end
                    2: begin
                        if (ridx[u] < 32) s_miso[u] <= sres[u][31 - ridx[u]];
                        ridx[u] <= ridx[u] + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issues one request on unit u and logs nss/sclk/mosi per cycle; index = cycle number after accept.
    task automatic run_frame(input int u, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit scramble, output int lat, output logic [31:0] res, output logic z);
        lat = -1;
        res = 'x;
        z   = 1'bx;
        @(negedge clock);
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        rv[u]      = 1'b1;
        for (int w = 0; w < 400 && rdy[u] !== 1'b1; w++) @(negedge clock);
        @(posedge clock);
        nss_q.delete();
        sclk_q.delete();
        mosi_q.delete();
        nss_q.push_back(1'b1);
        sclk_q.push_back(1'b0);
        mosi_q.push_back(1'b0);
        for (int c = 1; c <= 600; c++) begin
            @(negedge clock);
            if (c == 1) begin
                rv[u] = 1'b0;
                if (scramble) begin
                    req_opcode = 4'($urandom);
                    req_a      = $urandom;
                    req_b      = $urandom;
                end
            end
            nss_q.push_back(s_nss[u]);
            sclk_q.push_back(s_sclk[u]);
            mosi_q.push_back(s_mosi[u]);
            if (vld[u] === 1'b1) begin
                lat = c;
                res = result[u];
                z   = zr[u];
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        req_opcode = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            logic [5:0] obs;
            obs = {s_nss[u], s_sclk[u], s_mosi[u], rdy[u], vld[u], zr[u]};
            n_vec++;
            if (obs !== 6'b100100) begin
                n_bad++;
                $display("FAIL reset_outputs u%0d: got %b expected %b", u, obs, 6'b100100);
            end
            n_vec++;
            if (result[u] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_result u%0d: got %h expected %h", u, result[u], 32'd0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        int bad;
        logic [31:0] r;
        logic z;
        run_frame(0, 4'd0, 32'd5, 32'd7, 1'b0, lat, r, z);
        n_vec++;
        if (lat !== 170) begin n_bad++; $display("FAIL add_latency: got %0d expected %0d", lat, 170); end
        n_vec++;
        if (r !== 32'd12) begin n_bad++; $display("FAIL add_result: got %h expected %h", r, 32'd12); end
        n_vec++;
        if (z !== 1'b0) begin n_bad++; $display("FAIL add_zero: got %b expected %b", z, 1'b0); end
        bad = 0;
        for (int c = 1; c < nss_q.size(); c++)
            if (nss_q[c] !== (c > 169)) bad++;
        n_vec++;
        if (bad != 0) begin n_bad++; $display("FAIL add_nss_window: got %0d bad cycles expected %0d", bad, 0); end
    endtask

    task automatic test_sub();
        int lat;
        int hi;
        logic [3:0] first4;
        logic [31:0] r;
        logic z;
        run_frame(0, 4'd1, 32'd3, 32'd3, 1'b0, lat, r, z);
        n_vec++;
        if (r !== 32'd0) begin n_bad++; $display("FAIL sub_result: got %h expected %h", r, 32'd0); end
        n_vec++;
        if (z !== 1'b1) begin n_bad++; $display("FAIL sub_zero: got %b expected %b", z, 1'b1); end
        hi = 0;
        first4 = '0;
        for (int c = 1; c < sclk_q.size(); c++) begin
            if (sclk_q[c]) begin
                if (hi < 4) first4[3 - hi] = mosi_q[c];
                hi++;
            end
        end
        n_vec++;
        if (first4 !== 4'b0001) begin n_bad++; $display("FAIL sub_mosi_first4: got %b expected %b", first4, 4'b0001); end
        n_vec++;
        if (hi !== 68) begin n_bad++; $display("FAIL sub_sclk_count: got %0d expected %0d", hi, 68); end
    endtask

    task automatic test_sar();
        int lat;
        int bad;
        logic [31:0] r;
        logic z;
        run_frame(1, 4'd8, 32'h8000_0000, 32'd4, 1'b0, lat, r, z);
        n_vec++;
        if (lat !== 306) begin n_bad++; $display("FAIL sar_latency: got %0d expected %0d", lat, 306); end
        n_vec++;
        if (r !== 32'hF800_0000) begin n_bad++; $display("FAIL sar_result: got %h expected %h", r, 32'hF800_0000); end
        bad = 0;
        for (int c = 1; c < sclk_q.size(); c++)
            if (sclk_q[c] !== (c <= 272 && c % 4 == 0)) bad++;
        n_vec++;
        if (bad != 0) begin n_bad++; $display("FAIL sar_sclk_pattern: got %0d bad cycles expected %0d", bad, 0); end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1;
        int lat2 = -1;
        int fall = -1;
        logic [31:0] r1 = 'x;
        logic [31:0] r2 = 'x;
        @(negedge clock);
        req_opcode = 4'd4;
        req_a      = 32'hFFFF_0000;
        req_b      = 32'h0F0F_0F0F;
        rv[0]      = 1'b1;
        for (int w = 0; w < 400 && rdy[0] !== 1'b1; w++) @(negedge clock);
        @(posedge clock);
        for (int c = 1; c <= 800; c++) begin
            @(negedge clock);
            if (c == 1) begin
                req_opcode = 4'd6;
                req_a      = 32'd1;
                req_b      = 32'd31;
            end
            if (lat1 > 0 && fall < 0 && s_nss[0] === 1'b0) fall = c;
            if (vld[0] === 1'b1) begin
                if (lat1 < 0) begin
                    lat1 = c;
                    r1   = result[0];
                end else begin
                    lat2 = c;
                    r2   = result[0];
                    break;
                end
            end
        end
        rv[0] = 1'b0;
        n_vec++;
        if (r1 !== 32'hF0F0_0F0F) begin n_bad++; $display("FAIL b2b_result1: got %h expected %h", r1, 32'hF0F0_0F0F); end
        n_vec++;
        if (r2 !== 32'h8000_0000) begin n_bad++; $display("FAIL b2b_result2: got %h expected %h", r2, 32'h8000_0000); end
        n_vec++;
        if (lat1 !== 170) begin n_bad++; $display("FAIL b2b_latency1: got %0d expected %0d", lat1, 170); end
        n_vec++;
        if (fall !== lat1 + 1) begin n_bad++; $display("FAIL b2b_nss_fall: got %0d expected %0d", fall, lat1 + 1); end
        n_vec++;
        if (lat2 !== 340) begin n_bad++; $display("FAIL b2b_latency2: got %0d expected %0d", lat2, 340); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        logic [31:0] r;
        logic z;
        logic [2:0] obs;
        @(negedge clock);
        req_opcode = 4'd0;
        req_a      = 32'd5;
        req_b      = 32'd7;
        rv[0]      = 1'b1;
        for (int w = 0; w < 400 && rdy[0] !== 1'b1; w++) @(negedge clock);
        @(posedge clock);
        for (int c = 1; c < 50; c++) begin
            @(negedge clock);
            if (c == 1) rv[0] = 1'b0;
        end
        @(negedge clock);
        n_vec++;
        if (s_nss[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_busy_before: got nss=%b expected %b", s_nss[0], 1'b0); end
        reset = 1'b1;
        #1;
        obs = {s_nss[0], s_sclk[0], rdy[0]};
        n_vec++;
        if (obs !== 3'b101) begin n_bad++; $display("FAIL midreset_outputs: got %b expected %b", obs, 3'b101); end
        n_vec++;
        if (result[0] !== 32'd0) begin n_bad++; $display("FAIL midreset_result: got %h expected %h", result[0], 32'd0); end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clock);
            if (vld[0] === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_bad++; $display("FAIL midreset_no_rsp: got %0d pulses expected %0d", seen, 0); end
        run_frame(0, 4'd5, 32'd0, $urandom, 1'b0, lat, r, z);
        n_vec++;
        if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midreset_not_result: got %h expected %h", r, 32'hFFFF_FFFF); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int u;
            int lat;
            int bad;
            int unsigned l;
            int unsigned t;
            logic [3:0]  op;
            logic [31:0] a, b, r, exp;
            logic [67:0] fr;
            logic z;
            u  = i % 2;
            l  = (u == 0) ? L0 : L1;
            t  = 68 * (l + 1);
            op = 4'($urandom_range(0, 8));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            exp = alu_ref(op, a, b);
            fr  = {op, a, b};
            run_frame(u, op, a, b, 1'b1, lat, r, z);
            n_vec++;
            if (lat !== int'(t + 34)) begin n_bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, t + 34); end
            n_vec++;
            if (r !== exp) begin n_bad++; $display("FAIL rand%0d_result op%0d: got %h expected %h", i, op, r, exp); end
            n_vec++;
            if (z !== (exp == 32'd0)) begin n_bad++; $display("FAIL rand%0d_zero: got %b expected %b", i, z, exp == 32'd0); end
            bad = 0;
            for (int c = 1; c < nss_q.size(); c++) begin
                if (nss_q[c] !== (c > int'(t + 33))) bad++;
                if (sclk_q[c] !== (c <= int'(t) && c % int'(l + 1) == 0)) bad++;
                if (c <= int'(t) && mosi_q[c] !== fr[67 - (c - 1) / int'(l + 1)]) bad++;
            end
            n_vec++;
            if (bad != 0) begin n_bad++; $display("FAIL rand%0d_waveform: got %0d bad cycles expected %0d", i, bad, 0); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_sar();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
